// File: rtl/mc_control_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_control_fsm_if
//   Control-unit <-> datapath/memory bundle for the 16-bit multi-cycle RISC.
//   master : the control FSM (consumes opcode/flags/ready, drives controls)
//   slave  : the datapath side (drives opcode/flags/ready, consumes controls)
//
//   opcode     IR[15:12], valid from DECODE onward
//   zero       ALU zero flag, valid in BRANCH
//   mem_ready  memory completes the current access this cycle
//   pc_write / pc_src / ir_write / iord / mem_read / mem_write /
//   reg_write / reg_dst / mem_to_reg / alu_src_a / alu_src_b / alu_op
//              datapath controls
//   illegal_op one-cycle pulse in DECODE on an undefined opcode
//   bus_error  sticky watchdog trap flag
//   halted     FSM is in HALT
//   state      current state encoding (debug)
// ---------------------------------------------------------------------------
interface mc_control_fsm_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       bus_error;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, illegal_op, bus_error, halted, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, illegal_op, bus_error, halted, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Multi-cycle control unit for the 16-bit RISC datapath. Each instruction
//   walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK; memory states stall on
//   mem_ready and a wait-state watchdog traps a stuck access into HALT with
//   a sticky bus_error.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mc_control_fsm_if.master (opcode/zero/mem_ready in, controls out)
//
//   MAX_WAIT  stall cycles tolerated in one memory state (1..255)
//   WAIT_W    stall counter width
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            st, st_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              bus_err_q;
    logic              stall_state;
    logic              wd_expire;

    // raw decoded controls, before reset gating of the strobes
    logic       pc_write_r, ir_write_r, mem_read_r, mem_write_r;
    logic       reg_write_r, illegal_op_r;
    logic [1:0] pc_src_r, alu_src_b_r, alu_op_r;
    logic       iord_r, reg_dst_r, mem_to_reg_r, alu_src_a_r;

    // ---------------- watchdog ----------------
    assign stall_state = (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
    // mem_ready in the limit cycle wins: the access completes, no trap
    assign wd_expire   = stall_state && !bus.mem_ready && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        wait_nxt = '0;
        if (stall_state && !bus.mem_ready && !wd_expire)
            wait_nxt = wait_cnt + WAIT_W'(1);
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_FETCH;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            st       <= st_nxt;
            wait_cnt <= wait_nxt;
            if (wd_expire)
                bus_err_q <= 1'b1;
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        st_nxt       = st;
        pc_write_r   = 1'b0;
        pc_src_r     = 2'b00;
        ir_write_r   = 1'b0;
        iord_r       = 1'b0;
        mem_read_r   = 1'b0;
        mem_write_r  = 1'b0;
        reg_write_r  = 1'b0;
        reg_dst_r    = 1'b0;
        mem_to_reg_r = 1'b0;
        alu_src_a_r  = 1'b0;
        alu_src_b_r  = 2'b00;
        alu_op_r     = 2'b00;
        illegal_op_r = 1'b0;

        case (st)
            S_FETCH: begin
                mem_read_r  = 1'b1;
                alu_src_b_r = 2'b01;        // PC + 1
                ir_write_r  = bus.mem_ready;
                pc_write_r  = bus.mem_ready;
                if (wd_expire)          st_nxt = S_HALT;
                else if (bus.mem_ready) st_nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_r = 2'b10;        // PC + imm: branch target into ALUOut
                case (bus.opcode)
                    4'b0000, 4'b0001,
                    4'b0010, 4'b0011: st_nxt = S_EXEC_R;
                    OP_ADDI:          st_nxt = S_EXEC_I;
                    OP_LW, OP_SW:     st_nxt = S_MEM_ADDR;
                    OP_BEQ:           st_nxt = S_BRANCH;
                    OP_JMP:           st_nxt = S_JUMP;
                    OP_HALT:          st_nxt = S_HALT;
                    default: begin
                        illegal_op_r = 1'b1;
                        st_nxt       = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a_r = 1'b1;
                alu_op_r    = 2'b10;
                st_nxt      = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a_r = 1'b1;
                alu_src_b_r = 2'b10;
                st_nxt      = S_WB_I;
            end
            S_MEM_ADDR: begin
                alu_src_a_r = 1'b1;
                alu_src_b_r = 2'b10;
                if (bus.opcode == OP_LW)      st_nxt = S_MEM_RD;
                else if (bus.opcode == OP_SW) st_nxt = S_MEM_WR;
                else                          st_nxt = S_FETCH;
            end
            S_MEM_RD: begin
                mem_read_r = 1'b1;
                iord_r     = 1'b1;
                if (wd_expire)          st_nxt = S_HALT;
                else if (bus.mem_ready) st_nxt = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write_r = 1'b1;
                iord_r      = 1'b1;
                if (wd_expire)          st_nxt = S_HALT;
                else if (bus.mem_ready) st_nxt = S_FETCH;
            end
            S_WB_R: begin
                reg_write_r = 1'b1;
                reg_dst_r   = 1'b1;
                st_nxt      = S_FETCH;
            end
            S_WB_I: begin
                reg_write_r = 1'b1;
                st_nxt      = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write_r  = 1'b1;
                mem_to_reg_r = 1'b1;
                st_nxt       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_r = 1'b1;
                alu_op_r    = 2'b01;
                pc_src_r    = 2'b01;
                pc_write_r  = bus.zero;
                st_nxt      = S_FETCH;
            end
            S_JUMP: begin
                pc_src_r   = 2'b10;
                pc_write_r = 1'b1;
                st_nxt     = S_FETCH;
            end
            S_HALT:  st_nxt = S_HALT;
            default: st_nxt = S_FETCH;     // 13..15 recover
        endcase
    end

    // Strobes and enables are forced low while reset is held so nothing is
    // written even though the reset state (FETCH) would decode mem_read.
    assign bus.pc_write   = rst_n & pc_write_r;
    assign bus.ir_write   = rst_n & ir_write_r;
    assign bus.mem_read   = rst_n & mem_read_r;
    assign bus.mem_write  = rst_n & mem_write_r;
    assign bus.reg_write  = rst_n & reg_write_r;
    assign bus.illegal_op = rst_n & illegal_op_r;

    assign bus.pc_src     = pc_src_r;
    assign bus.iord       = iord_r;
    assign bus.reg_dst    = reg_dst_r;
    assign bus.mem_to_reg = mem_to_reg_r;
    assign bus.alu_src_a  = alu_src_a_r;
    assign bus.alu_src_b  = alu_src_b_r;
    assign bus.alu_op     = alu_op_r;
    assign bus.bus_error  = bus_err_q;
    assign bus.halted     = (st == S_HALT);
    assign bus.state      = st;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the 16-bit RISC datapath.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives every datapath mux select (memory address, ALU operands, PC source, register destination, writeback source) and every write enable.
- Stalls on a shared-memory ready handshake; a wait-state watchdog traps stuck memory accesses.

Parameters:
- MAX_WAIT, 15: maximum consecutive stall cycles in any memory state before a bus-error trap; range 1..255.
- WAIT_W, 8: width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  IR[15:12], valid from DECODE onward
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 branch target (ALUOut), 10 jump target
- ir_write  out  1  IR load enable
- iord  out  1  memory address mux: 0 PC, 1 ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 B, 01 constant 1, 10 sign-extended immediate
- alu_op  out  2  00 add, 01 sub, 10 funct from opcode[1:0]
- illegal_op  out  1  one-cycle pulse in DECODE for an undefined opcode
- bus_error  out  1  sticky; set on watchdog expiry
- halted  out  1  high in HALT
- state  out  4  current state encoding (debug)

Behaviour:
- Reset:
  - The asynchronous clear puts the FSM in FETCH, clears the stall counter, clears bus_error.
  - All strobes and enables are 0 while rst_n is low.
  - Deasserting rst_n mid-instruction aborts it; nothing is written.
- Outputs:
  - Moore-decoded from the state register; unlisted outputs are 0 in a state.
  - Exception: enables gated by mem_ready, or by zero in BRANCH.
- State encoding and transitions:
  - 0 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. ir_write=pc_write=mem_ready, pc_src=00. Go to DECODE on mem_ready, else stay.
  - 1 DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (precompute branch target). Route by opcode:
    - 0000–0011 R-type → EXEC_R
    - 0100 ADDI → EXEC_I
    - 0101 LW / 0110 SW → MEM_ADDR
    - 0111 BEQ → BRANCH
    - 1000 JMP → JUMP
    - 1111 → HALT
    - others: illegal_op=1 → FETCH (treated as NOP)
  - 2 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 → WB_R.
  - 3 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 → WB_I.
  - 4 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_RD if LW, MEM_WR if SW.
  - 5 MEM_RD: mem_read=1, iord=1. Go to WB_MEM on mem_ready.
  - 6 MEM_WR: mem_write=1, iord=1. Go to FETCH on mem_ready.
  - 7 WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
  - 8 WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
  - 9 WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
  - 10 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero → FETCH.
  - 11 JUMP: pc_src=10, pc_write=1 → FETCH.
  - 12 HALT: halted=1, all enables 0. Leaves only by reset.
  - 13–15: unreachable; any such state → FETCH next cycle.
- Latency with zero wait states: R-type 4, ADDI 4, LW 5, SW 4, BEQ 3, JMP 3, illegal 2 cycles.
- Each stall cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Watchdog:
  - The stall counter increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - It clears on mem_ready=1 or when entering any other state.
  - When the counter equals MAX_WAIT with mem_ready still 0: next state HALT, bus_error set.
  - If mem_ready arrives in the same cycle the limit is reached, the access completes normally and no error is raised.
- No pipelining: exactly one instruction in flight. mem_read and mem_write are never both 1.

Test Plan:
- Reset mid-MEM_RD (rst_n low for 2 cycles) → state=0, reg_write=0, bus_error=0; after release the FETCH strobes appear on the first edge.
- ADD (opcode 0000), mem_ready tied 1 → states 0,1,2,7,0; reg_write=1 only in cycle 4 with reg_dst=1; pc_write=1 only in cycle 1.
- LW with mem_ready low 3 cycles in MEM_RD → 8 total cycles; WB_MEM asserts reg_write=1, mem_to_reg=1.
- BEQ with zero=1 then zero=0 → pc_write=1, pc_src=01 in the first run; pc_write=0 in the second; both take 3 cycles.
- MAX_WAIT=4, mem_ready stuck 0 in FETCH → HALT after 5 cycles in FETCH; bus_error=1, halted=1, ir_write never 1.
- Opcode 1010 → illegal_op pulses 1 cycle in DECODE, no writes, back to FETCH on the third cycle. Opcode 1111 → halted=1 and held for 20 cycles.
